// File: rtl/multicycle_control.sv
// multicycle_control
//   Main control FSM of the multicycle RV64I core. Handles one instruction at
//   a time, steering the shared ALU, operand muxes, PC, register file and the
//   load/store splicers. Memory requests are held until mem_ready; a bounded
//   wait counter turns a hung bus into a sticky timeout trap.
//
//   alu_op encoding: SUM=0 SUB=1 AND=2 OR=3 XOR=4 SHIFT_LEFT=5 SHIFT_RIGHT=6
//                    SHIFT_RIGHT_A=7 EQUAL=8 LESS_U=9 LESS=10
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   opcode, funct3, funct7_5    instruction fields from the IR
//   alu_zero                    ALU result == 0
//   mem_ready                   memory completes the current request
//   mem_read, mem_write         memory requests (held until mem_ready)
//   ir_write, pc_write          IR latch / PC update enables
//   reg_write                   register-file write enable
//   alu_op, alu_src_a/b         ALU operation and operand selects
//   pc_source, file_write       PC source and write-back selects
//   splice_load, splice_store   load/store width selects
//   instr_done                  pulse on the last cycle of each instruction
//   trap, trap_cause            sticky halt and its cause (01 illegal, 10 timeout)
module multicycle_control #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [3:0] alu_op,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       pc_source,
    output logic [1:0] file_write,
    output logic [1:0] splice_load,
    output logic [1:0] splice_store,
    output logic       instr_done,
    output logic       trap,
    output logic [1:0] trap_cause
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_EXEC_R   = 4'd3;
    localparam logic [3:0] S_EXEC_I   = 4'd4;
    localparam logic [3:0] S_LUI      = 4'd5;
    localparam logic [3:0] S_WB_ALU   = 4'd6;
    localparam logic [3:0] S_MEM_ADDR = 4'd7;
    localparam logic [3:0] S_MEM_RD   = 4'd8;
    localparam logic [3:0] S_MEM_WB   = 4'd9;
    localparam logic [3:0] S_MEM_WR   = 4'd10;
    localparam logic [3:0] S_BRANCH   = 4'd11;
    localparam logic [3:0] S_JAL      = 4'd12;
    localparam logic [3:0] S_JALR     = 4'd13;
    localparam logic [3:0] S_TRAP     = 4'd14;

    localparam logic [3:0] OP_SUM   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_LESS  = 4'd10;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    logic [3:0]  state, next_state;
    logic [1:0]  cause_reg, next_cause;
    logic [15:0] wait_cnt;
    logic        waiting, timeout;
    logic [3:0]  exec_fn;
    logic        exec_ok;
    logic        load_ok, store_ok, taken;

    assign waiting = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    // wait_cnt holds the number of already-elapsed cycles without ready, so
    // the MAX_WAIT-th cycle is the one where it equals MAX_WAIT-1.
    assign timeout = (wait_cnt == 16'(MAX_WAIT - 1));

    // Loads: LH/LW/LD (001..011) and LBU (100). Stores: SB..SD (000..011).
    assign load_ok  = funct3[2] ? (funct3[1:0] == 2'b00) : (funct3[1:0] != 2'b00);
    assign store_ok = !funct3[2];
    // BEQ/BGE take on zero, BNE/BLT on non-zero.
    assign taken    = alu_zero ^ funct3[0] ^ funct3[2];

    always_comb begin
        exec_ok = 1'b1;
        exec_fn = OP_SUM;
        case (funct3)
            3'b000:  exec_fn = (state == S_EXEC_R && funct7_5) ? OP_SUB : OP_SUM;
            3'b001:  exec_fn = OP_SLL;
            3'b010:  exec_fn = OP_LESS;
            3'b100:  exec_fn = OP_XOR;
            3'b101:  exec_fn = funct7_5 ? OP_SRA : OP_SRL;
            3'b111:  exec_fn = OP_AND;
            default: exec_ok = 1'b0;
        endcase
    end

    always_comb begin
        next_state   = state;
        next_cause   = cause_reg;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        reg_write    = 1'b0;
        alu_op       = OP_SUM;
        alu_src_a    = 2'd0;
        alu_src_b    = 2'd0;
        pc_source    = 1'b0;
        file_write   = 2'd0;
        splice_load  = 2'd0;
        splice_store = 2'd0;
        instr_done   = 1'b0;
        case (state)
            S_IDLE: next_state = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = S_DECODE;
                end else if (timeout) begin
                    next_state = S_TRAP;
                    next_cause = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'd3;
                case (opcode)
                    7'b0110011: next_state = S_EXEC_R;
                    7'b0010011: next_state = S_EXEC_I;
                    7'b0000011,
                    7'b0100011: next_state = S_MEM_ADDR;
                    7'b1100011: next_state = S_BRANCH;
                    7'b1101111: next_state = S_JAL;
                    7'b1100111: next_state = S_JALR;
                    7'b0110111: next_state = S_LUI;
                    default: begin
                        next_state = S_TRAP;
                        next_cause = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_EXEC_R, S_EXEC_I: begin
                alu_src_a = 2'd1;
                alu_src_b = (state == S_EXEC_I) ? 2'd2 : 2'd0;
                if (exec_ok) begin
                    alu_op     = exec_fn;
                    next_state = S_WB_ALU;
                end else begin
                    next_state = S_TRAP;
                    next_cause = CAUSE_ILLEGAL;
                end
            end
            S_LUI: begin
                alu_src_a  = 2'd2;
                alu_src_b  = 2'd2;
                next_state = S_WB_ALU;
            end
            S_WB_ALU: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                if (opcode[5] ? store_ok : load_ok) begin
                    next_state = opcode[5] ? S_MEM_WR : S_MEM_RD;
                end else begin
                    next_state = S_TRAP;
                    next_cause = CAUSE_ILLEGAL;
                end
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    next_state = S_MEM_WB;
                end else if (timeout) begin
                    next_state = S_TRAP;
                    next_cause = CAUSE_TIMEOUT;
                end
            end
            S_MEM_WB: begin
                reg_write   = 1'b1;
                file_write  = 2'd1;
                splice_load = 2'd3 - funct3[1:0];
                instr_done  = 1'b1;
                next_state  = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write    = 1'b1;
                splice_store = 2'd3 - funct3[1:0];
                if (mem_ready) begin
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end else if (timeout) begin
                    next_state = S_TRAP;
                    next_cause = CAUSE_TIMEOUT;
                end
            end
            S_BRANCH: begin
                alu_src_a = 2'd1;
                if (!funct3[1]) begin
                    alu_op     = funct3[2] ? OP_LESS : OP_SUB;
                    pc_write   = taken;
                    pc_source  = 1'b1;
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end else begin
                    next_state = S_TRAP;
                    next_cause = CAUSE_ILLEGAL;
                end
            end
            S_JAL: begin
                reg_write  = 1'b1;
                file_write = 2'd2;
                pc_write   = 1'b1;
                pc_source  = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_JALR: begin
                alu_src_a  = 2'd1;
                alu_src_b  = 2'd2;
                reg_write  = 1'b1;
                file_write = 2'd2;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_TRAP: next_state = S_TRAP;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cause_reg <= '0;
            wait_cnt  <= '0;
        end else begin
            state     <= next_state;
            cause_reg <= next_cause;
            // Counter is zero whenever a waiting state is entered, since it
            // clears on every cycle that is not an unanswered request.
            if (waiting && !mem_ready) begin
                wait_cnt <= wait_cnt + 16'd1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    assign trap       = (state == S_TRAP);
    assign trap_cause = cause_reg;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    localparam int MW = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       funct7_5 = 1'b0;
    logic       alu_zero = 1'b0;
    logic       mem_ready;
    logic       mem_read, mem_write, ir_write, pc_write, reg_write;
    logic [3:0] alu_op;
    logic [1:0] alu_src_a, alu_src_b;
    logic       pc_source;
    logic [1:0] file_write, splice_load, splice_store;
    logic       instr_done, trap;
    logic [1:0] trap_cause;

    always #5 clk = ~clk;

    multicycle_control #(.MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .alu_zero(alu_zero), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .alu_op(alu_op),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
        .file_write(file_write), .splice_load(splice_load),
        .splice_store(splice_store), .instr_done(instr_done), .trap(trap),
        .trap_cause(trap_cause)
    );

    // Expected summary of one instruction, as seen at instr_done or trap.
    typedef struct {
        bit trap_k;
        int cause;
        int cyc;
        int nreg;
        int fw;
        int npc;
        int pcs;
        int ndr;
        int ndw;
        int spl;
        int sps;
        int op;
        int a;
        int b;
    } rec_t;

    rec_t sbq[$];
    int   dq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Operation per funct3 for register/immediate ALU ops (-1 = unsupported).
    int r_tab[8]  = '{0, 5, 10, -1, 4, 6, -1, 2};
    // Splice select per funct3 for loads/stores (-1 = unsupported).
    int ld_tab[8] = '{-1, 2, 1, 0, 3, -1, -1, -1};
    int st_tab[8] = '{3, 2, 1, 0, -1, -1, -1, -1};

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int all_outputs();
        return int'({mem_read, mem_write, ir_write, pc_write, reg_write, alu_op,
                     alu_src_a, alu_src_b, pc_source, file_write, splice_load,
                     splice_store, instr_done, trap, trap_cause});
    endfunction

    function automatic int pick_delay();
        int r;
        r = $urandom_range(0, 19);
        if (r < 10) return 0;
        if (r < 16) return $urandom_range(1, 3);
        if (r < 19) return MW - 1;
        return MW;
    endfunction

    // Memory model: answers each new request after the delay queued for it.
    initial begin
        bit in_req;
        int cur_delay, wait_n;
        in_req = 0;
        cur_delay = 0;
        wait_n = 0;
        mem_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                in_req = 0;
                mem_ready = 1'b0;
            end else begin
                if (mem_ready || !(mem_read || mem_write)) begin
                    in_req = 0;
                    mem_ready = 1'b0;
                end
                if ((mem_read || mem_write) && !in_req) begin
                    in_req = 1;
                    wait_n = 0;
                    cur_delay = (dq.size() > 0) ? dq.pop_front() : 0;
                end
                if (in_req) begin
                    mem_ready = (wait_n == cur_delay);
                    wait_n++;
                end
            end
        end
    end

    // Monitor: gathers per-instruction observations, checks against the queue.
    initial begin
        bit   running, seen_ir, trap_q, fetch_ok;
        int   cyc, pf, nreg, fw, npc, pcs, ndr, ndw, spl, sps, op, a, b, dec;
        rec_t e;
        running = 0; seen_ir = 0; trap_q = 0; fetch_ok = 0;
        cyc = 0; pf = 0; nreg = 0; fw = 0; npc = 0; pcs = 0; ndr = 0; ndw = 0;
        spl = 0; sps = 0; op = 0; a = 0; b = 0; dec = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                running = 0;
                trap_q = 0;
            end else begin
                if (!running && mem_read) begin
                    running = 1; seen_ir = 0; fetch_ok = 0;
                    cyc = 0; pf = 0; nreg = 0; fw = 0; npc = 0; pcs = 0;
                    ndr = 0; ndw = 0; spl = 0; sps = 0; op = 0; a = 0; b = 0; dec = 0;
                end
                if (running) begin
                    cyc++;
                    if (seen_ir) begin
                        pf++;
                        if (pf == 1) dec = int'({alu_op, alu_src_a, alu_src_b});
                        if (pf == 2) begin
                            op = alu_op; a = alu_src_a; b = alu_src_b;
                        end
                    end
                    if (reg_write) begin
                        nreg++; fw = file_write; spl = splice_load;
                    end
                    if (pc_write && !ir_write) begin
                        npc++; pcs = pc_source;
                    end
                    if (seen_ir && mem_read) ndr++;
                    if (mem_write) begin
                        ndw++; sps = splice_store;
                    end
                    if (ir_write) begin
                        seen_ir = 1;
                        fetch_ok = pc_write && !pc_source && alu_src_a == 2'd0 &&
                                   alu_src_b == 2'd1 && alu_op == 4'd0;
                    end
                end
                if (instr_done || (trap && !trap_q)) begin
                    if (sbq.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL scoreboard: unexpected completion, trap=%0d (t=%0t)", trap, $time);
                    end else begin
                        e = sbq.pop_front();
                        chk("completion_kind", int'(trap), int'(e.trap_k));
                        if (trap == e.trap_k) begin
                            chk("latency", cyc, e.cyc);
                            if (e.trap_k) begin
                                chk("trap_cause", int'(trap_cause), e.cause);
                            end else begin
                                chk("fetch_ctrl", int'(fetch_ok), 1);
                                chk("decode_ctrl", dec, 3);
                                chk("reg_writes", nreg, e.nreg);
                                chk("file_write", fw, e.fw);
                                chk("pc_writes", npc, e.npc);
                                chk("pc_source", pcs, e.pcs);
                                chk("data_read_cycles", ndr, e.ndr);
                                chk("data_write_cycles", ndw, e.ndw);
                                chk("splice_load", spl, e.spl);
                                chk("splice_store", sps, e.sps);
                                chk("exec_alu_op", op, e.op);
                                chk("exec_src_a", a, e.a);
                                chk("exec_src_b", b, e.b);
                            end
                        end
                    end
                    running = 0;
                end
                trap_q = trap;
            end
        end
    end

    // Reference model: expected outcome of one randomly chosen instruction.
    task automatic plan_instr(output logic [6:0] o7, output logic [2:0] f3,
                              output logic f7, output logic az,
                              output bit ends, output int cause);
        rec_t r;
        int   k, fd, dd, t;
        bit   tk;
        logic [6:0] bad_ops [4];
        bad_ops = '{7'b0001111, 7'b1110011, 7'b0010111, 7'b0000000};
        r = '{default: 0};
        tk = 0;
        k  = $urandom_range(0, 19);
        f3 = 3'($urandom_range(0, 7));
        f7 = 1'($urandom_range(0, 1));
        az = 1'($urandom_range(0, 1));
        fd = pick_delay();
        dd = pick_delay();
        dq.push_back(fd);
        if (k < 4)       o7 = 7'b0110011;
        else if (k < 8)  o7 = 7'b0010011;
        else if (k == 8) o7 = 7'b0110111;
        else if (k < 12) o7 = 7'b0000011;
        else if (k < 15) o7 = 7'b0100011;
        else if (k < 17) o7 = 7'b1100011;
        else if (k == 17) o7 = 7'b1101111;
        else if (k == 18) o7 = 7'b1100111;
        else o7 = bad_ops[$urandom_range(0, 3)];
        // Keep most encodings legal so episodes run several instructions.
        if (k < 15 && $urandom_range(0, 3) != 0) f3 = 3'b010;
        if (k >= 15 && k < 17 && f3[1] && $urandom_range(0, 3) != 0) f3 = 3'b001;
        if (k < 4 && f3 != 3'd0 && f3 != 3'd5) f7 = 1'b0;

        if (fd >= MW) begin
            r.trap_k = 1; r.cause = 2; r.cyc = MW + 1;
        end else if (k < 8) begin
            t = r_tab[f3];
            if (k < 4 && f3 == 3'd0 && f7) t = 1;
            if (f3 == 3'd5 && f7) t = 7;
            if (t < 0) begin
                r.trap_k = 1; r.cause = 1; r.cyc = fd + 4;
            end else begin
                r.cyc = fd + 4; r.nreg = 1; r.fw = 0;
                r.op = t; r.a = 1; r.b = (k < 4) ? 0 : 2;
            end
        end else if (k == 8) begin
            r.cyc = fd + 4; r.nreg = 1; r.op = 0; r.a = 2; r.b = 2;
        end else if (k < 15) begin
            t = (k < 12) ? ld_tab[f3] : st_tab[f3];
            if (t < 0) begin
                r.trap_k = 1; r.cause = 1; r.cyc = fd + 4;
            end else begin
                dq.push_back(dd);
                r.op = 0; r.a = 1; r.b = 2;
                if (dd >= MW) begin
                    r.trap_k = 1; r.cause = 2; r.cyc = fd + MW + 4;
                end else if (k < 12) begin
                    r.cyc = fd + dd + 5; r.nreg = 1; r.fw = 1;
                    r.ndr = dd + 1; r.spl = t;
                end else begin
                    r.cyc = fd + dd + 4; r.ndw = dd + 1; r.sps = t;
                end
            end
        end else if (k < 17) begin
            if (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5) begin
                case (f3)
                    3'd0:    tk = az;
                    3'd1:    tk = !az;
                    3'd4:    tk = !az;
                    default: tk = az;
                endcase
                r.cyc = fd + 3; r.npc = tk ? 1 : 0; r.pcs = tk ? 1 : 0;
                r.op = (f3 < 3'd4) ? 1 : 10; r.a = 1; r.b = 0;
            end else begin
                r.trap_k = 1; r.cause = 1; r.cyc = fd + 4;
            end
        end else if (k == 17) begin
            r.cyc = fd + 3; r.nreg = 1; r.fw = 2; r.npc = 1; r.pcs = 1;
        end else if (k == 18) begin
            r.cyc = fd + 3; r.nreg = 1; r.fw = 2; r.npc = 1; r.pcs = 0;
            r.op = 0; r.a = 1; r.b = 2;
        end else begin
            r.trap_k = 1; r.cause = 1; r.cyc = fd + 3;
        end
        sbq.push_back(r);
        ends  = r.trap_k;
        cause = r.cause;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        dq.delete();
        sbq.delete();
        repeat (2) @(posedge clk);
        #3;
        chk("reset_outputs", all_outputs(), 0);
        rst_n = 1'b1;
    endtask

    task automatic wait_event(output bit got);
        got = 0;
        for (int i = 0; i < 200; i++) begin
            if (instr_done || trap) begin
                got = 1;
                break;
            end
            @(posedge clk);
            #3;
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL event_wait: no instr_done/trap within 200 cycles (t=%0t)", $time);
        end
    endtask

    task automatic hold_check(input int cause);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #3;
            chk("trap_no_read", int'(mem_read), 0);
            chk("trap_no_write", int'(mem_write), 0);
            chk("trap_sticky", int'(trap), 1);
            chk("trap_cause_held", int'(trap_cause), cause);
        end
    endtask

    initial begin
        logic [6:0] o7;
        logic [2:0] f3;
        logic       f7, az;
        bit         ends, got;
        int         cause;
        rec_t       r;

        for (int ep = 0; ep < 20; ep++) begin
            do_reset();
            for (int n = 0; n < 15; n++) begin
                plan_instr(o7, f3, f7, az, ends, cause);
                @(posedge clk);
                #3;
                opcode = o7; funct3 = f3; funct7_5 = f7; alu_zero = az;
                wait_event(got);
                if (!got) break;
                if (trap) begin
                    if (ends) hold_check(cause);
                    break;
                end
            end
        end

        // Asynchronous reset in the middle of a store request.
        do_reset();
        dq.push_back(0);
        dq.push_back(3);
        @(posedge clk);
        #3;
        opcode = 7'b0100011; funct3 = 3'b010;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if (mem_write) begin
                got = 1;
                break;
            end
            @(posedge clk);
            #3;
        end
        chk("store_request_seen", int'(got), 1);
        rst_n = 1'b0;
        #1;
        chk("async_drop_mem_write", int'(mem_write), 0);
        chk("async_reset_outputs", all_outputs(), 0);
        dq.delete();
        sbq.delete();
        r = '{default: 0};
        r.trap_k = 1; r.cause = 1; r.cyc = 3;
        sbq.push_back(r);
        dq.push_back(0);
        opcode = 7'b0001111;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        chk("idle_after_release", int'(mem_read), 0);
        @(posedge clk);
        #3;
        chk("fetch_after_idle", int'(mem_read), 1);
        wait_event(got);
        if (got) begin
            chk("illegal_trap", int'(trap), 1);
            hold_check(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
